// File: rtl/control_pkg.sv
// Shared opcodes, sequencer states and control-word layout.
// SEQ_CARRY_FLAG_EN enables the carry flag and the JC instruction.
package control_pkg;

  localparam int OPC_W = 4;
  localparam int OPR_W = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_EXEC0,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_e;

  typedef struct packed {
    logic alu_en;
    logic rega_en;
    logic regb_en;
    logic pc_en;
    logic ram_en;
    logic ir_en;
    logic rega_we;
    logic regb_we;
    logic mar_we;
    logic ram_we;
    logic ir_we;
    logic out_we;
    logic pc_inc;
    logic pc_load;
    logic sub_en;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational state + opcode (+ carry flag) to control-word decoder.
// SEQ_CARRY_FLAG_EN makes JC load the PC when the flag is set.
module control_decode
  import control_pkg::*;
(
  input  state_e  state,
  input  opcode_t opcode,
  input  logic    flag,
  output ctrl_t   ctrl
);

`ifndef SEQ_CARRY_FLAG_EN
  logic unused_flag;
  assign unused_flag = flag;
`endif

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH0: begin
        ctrl.pc_en  = 1'b1;
        ctrl.mar_we = 1'b1;
      end
      S_FETCH1: begin
        ctrl.ram_en = 1'b1;
        ctrl.ir_we  = 1'b1;
        ctrl.pc_inc = 1'b1;
      end
      S_EXEC0: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_en  = 1'b1;
            ctrl.mar_we = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_en   = 1'b1;
            ctrl.rega_we = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_en   = 1'b1;
            ctrl.pc_load = 1'b1;
          end
`ifdef SEQ_CARRY_FLAG_EN
          OP_JC: begin
            ctrl.ir_en   = 1'b1;
            ctrl.pc_load = flag;
          end
`endif
          OP_OUT: begin
            ctrl.rega_en = 1'b1;
            ctrl.out_we  = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC1: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_en  = 1'b1;
            ctrl.rega_we = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_en  = 1'b1;
            ctrl.regb_we = 1'b1;
          end
          OP_STA: begin
            ctrl.rega_en = 1'b1;
            ctrl.ram_we  = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_en  = 1'b1;
          ctrl.rega_we = 1'b1;
          ctrl.sub_en  = (opcode == OP_SUB);
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: state and carry-flag registers around control_decode.
// SEQ_CARRY_FLAG_EN adds the carry flag captured at the end of ADD/SUB.
module control_sequencer
  import control_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             carry_in,
  output logic             alu_enable,
  output logic             rega_enable,
  output logic             regb_enable,
  output logic             pc_enable,
  output logic             ram_enable,
  output logic             ir_enable,
  output logic             rega_write_enable,
  output logic             regb_write_enable,
  output logic             mar_write_enable,
  output logic             ram_write_enable,
  output logic             ir_write_enable,
  output logic             out_write_enable,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             sub_enable,
  output logic             halted
);

  state_e  state_q, state_d;
  opcode_t opcode;
  logic    flag;
  ctrl_t   ctrl_raw, ctrl;

  logic [WIDTH-OPC_W-1:0] unused_operand;
  assign unused_operand = instr[WIDTH-OPC_W-1:0];
  assign opcode = instr[WIDTH-1 -: OPC_W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_EXEC0;
      S_EXEC0: begin
        case (opcode)
          OP_LDA, OP_STA,
          OP_ADD, OP_SUB: state_d = S_EXEC1;
          OP_HLT:         state_d = S_HALT;
          default:        state_d = S_FETCH0;
        endcase
      end
      S_EXEC1: begin
        if (opcode == OP_ADD || opcode == OP_SUB) state_d = S_EXEC2;
        else                                      state_d = S_FETCH0;
      end
      S_EXEC2: state_d = S_FETCH0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH0;
    endcase
  end

`ifdef SEQ_CARRY_FLAG_EN
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (state_q == S_EXEC2 &&
        (opcode == OP_ADD || opcode == OP_SUB))
      flag_d = carry_in;
  end

  assign flag = flag_q;
`else
  logic unused_carry;
  assign unused_carry = carry_in;
  assign flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH0;
`ifdef SEQ_CARRY_FLAG_EN
      flag_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SEQ_CARRY_FLAG_EN
      flag_q  <= flag_d;
`endif
    end
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .flag   (flag),
    .ctrl   (ctrl_raw)
  );

  // Reset must suppress every strobe in the same cycle, not one later.
  assign ctrl = rst_n ? ctrl_raw : '0;

  assign alu_enable        = ctrl.alu_en;
  assign rega_enable       = ctrl.rega_en;
  assign regb_enable       = ctrl.regb_en;
  assign pc_enable         = ctrl.pc_en;
  assign ram_enable        = ctrl.ram_en;
  assign ir_enable         = ctrl.ir_en;
  assign rega_write_enable = ctrl.rega_we;
  assign regb_write_enable = ctrl.regb_we;
  assign mar_write_enable  = ctrl.mar_we;
  assign ram_write_enable  = ctrl.ram_we;
  assign ir_write_enable   = ctrl.ir_we;
  assign out_write_enable  = ctrl.out_we;
  assign pc_inc            = ctrl.pc_inc;
  assign pc_load           = ctrl.pc_load;
  assign sub_enable        = ctrl.sub_en;
  assign halted            = ctrl.halted;

endmodule
